// File: rtl/wb_spram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_spram_pkg
// Description : Shared types and parameter checks for the Wishbone SPRAM.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_spram_pkg;

    localparam int c_data_w = 32;
    localparam int c_sel_w  = 4;

    // One slot of the response pipeline: a response is pending and is an error.
    typedef struct packed {
        logic valid;
        logic err;
    } resp_stage_t;

    function automatic bit read_latency_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_if
// Description : Wishbone B4 pipelined bus bundle, clock and reset included.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        stall;

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_i,
        output dat_o, ack, err, stall
    );

    modport master (
        input  clk, rst, dat_o, ack, err, stall,
        output cyc, stb, we, adr, sel, dat_i
    );
endinterface
`default_nettype wire

// File: rtl/spram_be.sv
`default_nettype none
// ============================================================================
// Module      : spram_be
// Description : Byte-enabled synchronous single-port RAM, optional output reg.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_be #(
    parameter int    DEPTH     = 32,
    parameter int    ADDR_W    = 5,
    parameter string INIT_FILE = "",
    parameter bit    OUT_REG   = 1'b0
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rd <= r_mem[i_addr];
            end
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [31:0] r_rd_q;
        always_ff @(posedge clk) begin
            r_rd_q <= r_rd;
        end
        assign o_rdata = r_rd_q;
    end else begin : g_out_direct
        assign o_rdata = r_rd;
    end

endmodule
`default_nettype wire

// File: rtl/wb_spram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wb_spram_pipe
// Description : Wishbone B4 pipelined slave around a byte-enabled SPRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_spram_pipe
    import wb_spram_pkg::*;
#(
    parameter int    SIZE         = 'h80,
    parameter int    READ_LATENCY = 1,
    parameter bit    READ_ONLY    = 1'b0,
    parameter string INIT_FILE    = ""
) (
    wb_if.slave wb
);
    localparam int c_depth = SIZE / 4;
    localparam int c_aw    = $clog2(SIZE) - 2;
    localparam logic [c_aw:0] c_depth_w = c_depth[c_aw:0];

    if (!read_latency_legal(READ_LATENCY) || (SIZE % 4) != 0 || SIZE < 8) begin : g_param_check
        $fatal(1, "wb_spram_pipe: illegal SIZE or READ_LATENCY");
    end

    logic              w_req;
    logic              w_accept;
    logic [c_aw-1:0]   w_idx;
    logic              w_oor;
    logic              w_wr_denied;
    logic              w_err;
    logic              w_ram_en;
    logic [31:0]       w_rdata;
    logic              w_unused_adr;
    resp_stage_t       r_pipe [READ_LATENCY];

    assign w_req        = wb.cyc & wb.stb;
    assign w_accept     = w_req & ~wb.rst;
    assign w_idx        = wb.adr[c_aw+1:2];
    assign w_oor        = {1'b0, w_idx} >= c_depth_w;
    assign w_wr_denied  = wb.we & READ_ONLY;
    assign w_err        = w_oor | w_wr_denied;
    assign w_ram_en     = w_accept & ~w_err;
    // Upper address bits alias by design; byte offset is covered by sel.
    assign w_unused_adr = ^{wb.adr[31:c_aw+2], wb.adr[1:0]};

    // Dropping cyc abandons the bus cycle, so every pending response is discarded.
    always_ff @(posedge wb.clk) begin
        if (wb.rst || !wb.cyc) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: w_req, err: w_err};
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    spram_be #(
        .DEPTH     (c_depth),
        .ADDR_W    (c_aw),
        .INIT_FILE (INIT_FILE),
        .OUT_REG   (READ_LATENCY == 2)
    ) u_ram (
        .clk     (wb.clk),
        .i_en    (w_ram_en),
        .i_we    (wb.we),
        .i_be    (wb.sel),
        .i_addr  (w_idx),
        .i_wdata (wb.dat_i),
        .o_rdata (w_rdata)
    );

    assign wb.ack   = r_pipe[READ_LATENCY-1].valid & ~r_pipe[READ_LATENCY-1].err & wb.cyc & ~wb.rst;
    assign wb.err   = r_pipe[READ_LATENCY-1].valid &  r_pipe[READ_LATENCY-1].err & wb.cyc & ~wb.rst;
    assign wb.stall = 1'b0;
    assign wb.dat_o = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_spram_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_spram_pipe
// Description : Directed vector bench for three wb_spram_pipe configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_spram_pipe;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    wb_if wb_a (.clk(clk), .rst(rst));
    wb_if wb_b (.clk(clk), .rst(rst));
    wb_if wb_c (.clk(clk), .rst(rst));

    wb_spram_pipe #(.SIZE('h80), .READ_LATENCY(1), .READ_ONLY(1'b0), .INIT_FILE("")) dut_a (.wb(wb_a));
    wb_spram_pipe #(.SIZE('h80), .READ_LATENCY(2), .READ_ONLY(1'b0), .INIT_FILE("")) dut_b (.wb(wb_b));
    wb_spram_pipe #(.SIZE('h60), .READ_LATENCY(1), .READ_ONLY(1'b1), .INIT_FILE("")) dut_c (.wb(wb_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          d;
        bit          r, c, s, w;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        bit          e_ack, e_err, e_dchk;
        logic [31:0] e_dat;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int d, input bit r, c, s, w, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] wdat,
                       input bit e_ack, e_err, e_dchk, input logic [31:0] e_dat, input string tag);
        vec_t v;
        v.d = d; v.r = r; v.c = c; v.s = s; v.w = w; v.adr = adr; v.sel = sel; v.wdat = wdat;
        v.e_ack = e_ack; v.e_err = e_err; v.e_dchk = e_dchk; v.e_dat = e_dat; v.tag = tag;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // One bus cycle: inputs change at negedge, outputs sampled 1 ns later.
    task automatic step(input int d, input bit r, c, s, w, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] wdat,
                        input bit e_ack, e_err, e_dchk, input logic [31:0] e_dat,
                        input string tag, output logic [31:0] rdat);
        logic ack, err, stall;
        @(negedge clk);
        rst = r;
        wb_a.cyc = (d == 0) && c; wb_a.stb = (d == 0) && s; wb_a.we = w;
        wb_a.adr = adr; wb_a.sel = sel; wb_a.dat_i = wdat;
        wb_b.cyc = (d == 1) && c; wb_b.stb = (d == 1) && s; wb_b.we = w;
        wb_b.adr = adr; wb_b.sel = sel; wb_b.dat_i = wdat;
        wb_c.cyc = (d == 2) && c; wb_c.stb = (d == 2) && s; wb_c.we = w;
        wb_c.adr = adr; wb_c.sel = sel; wb_c.dat_i = wdat;
        #1;
        case (d)
            0:       begin ack = wb_a.ack; err = wb_a.err; stall = wb_a.stall; rdat = wb_a.dat_o; end
            1:       begin ack = wb_b.ack; err = wb_b.err; stall = wb_b.stall; rdat = wb_b.dat_o; end
            default: begin ack = wb_c.ack; err = wb_c.err; stall = wb_c.stall; rdat = wb_c.dat_o; end
        endcase
        n_cmp++;
        if (ack !== e_ack) begin
            n_bad++;
            $display("FAIL %s ack: got %0b want %0b", tag, ack, e_ack);
        end
        n_cmp++;
        if (err !== e_err) begin
            n_bad++;
            $display("FAIL %s err: got %0b want %0b", tag, err, e_err);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL %s stall: got %0b want 0", tag, stall);
        end
        if (e_dchk) begin
            n_cmp++;
            if (rdat !== e_dat) begin
                n_bad++;
                $display("FAIL %s dat_o: got %08h want %08h", tag, rdat, e_dat);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] v0;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;

        // reset state of every instance
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_a");
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_b");
        add(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_c");
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        // A: latency 1, write/read, lane masks, last word, aliasing
        add(0, 0, 1, 1, 1, 'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, "a_wr10");
        add(0, 0, 1, 1, 0, 'h10, 4'hF, 0,            1, 0, 0, 0, "a_rd10");
        add(0, 0, 1, 0, 0, 0,    4'h0, 0,            1, 0, 1, 32'hDEADBEEF, "a_rd10_data");
        add(0, 0, 1, 1, 1, 'h20, 4'hF, 32'h11223344, 0, 0, 0, 0, "a_wr20");
        add(0, 0, 1, 1, 1, 'h20, 4'b0010, 32'hAAAAAAAA, 1, 0, 0, 0, "a_wr20_lane1");
        add(0, 0, 1, 1, 0, 'h20, 4'hF, 0,            1, 0, 0, 0, "a_rd20");
        add(0, 0, 1, 1, 1, 'h20, 4'h0, 32'hFFFFFFFF, 1, 0, 1, 32'h1122AA44, "a_wr20_sel0");
        add(0, 0, 1, 1, 0, 'h20, 4'hF, 0,            1, 0, 0, 0, "a_rd20_again");
        add(0, 0, 1, 1, 1, 'h7C, 4'hF, 32'h01020304, 1, 0, 1, 32'h1122AA44, "a_wr7c");
        add(0, 0, 1, 1, 1, 'h7C, 4'b1001, 32'hFFFFFFFF, 1, 0, 0, 0, "a_wr7c_lanes03");
        add(0, 0, 1, 1, 0, 'h7C, 4'hF, 0,            1, 0, 0, 0, "a_rd7c");
        add(0, 0, 1, 1, 0, 'h90, 4'hF, 0,            1, 0, 1, 32'hFF0203FF, "a_rd_alias");
        add(0, 0, 1, 0, 0, 0,    4'h0, 0,            1, 0, 1, 32'hDEADBEEF, "a_alias_data");
        add(0, 0, 0, 0, 0, 0,    4'h0, 0,            0, 0, 0, 0, "a_idle");
        // C: SIZE 0x60, read-only, out-of-range
        add(2, 0, 1, 1, 0, 'h5C, 4'hF, 0,            0, 0, 0, 0, "c_rd5c");
        add(2, 0, 1, 1, 0, 'h60, 4'hF, 0,            1, 0, 0, 0, "c_rd60");
        add(2, 0, 1, 1, 1, 'h00, 4'hF, 32'hA5A5A5A5, 0, 1, 0, 0, "c_wr_ro");
        add(2, 0, 1, 1, 0, 'h7C, 4'hF, 0,            0, 1, 0, 0, "c_rd7c");
        add(2, 0, 1, 0, 0, 0,    4'h0, 0,            0, 1, 0, 0, "c_err7c");
        add(2, 0, 0, 0, 0, 0,    4'h0, 0,            0, 0, 0, 0, "c_idle");
        // B: latency 2, eight writes then eight back-to-back reads
        add(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, "b_idle");
        for (int i = 0; i < 8; i++)
            add(1, 0, 1, 1, 1, 32'(4*i), 4'hF, pat(i), i >= 2, 0, 0, 0, "b_wr");
        add(1, 0, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, "b_wr_tail");
        add(1, 0, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, "b_wr_tail");
        for (int i = 0; i < 8; i++)
            add(1, 0, 1, 1, 0, 32'(4*i), 4'hF, 0, i >= 2, 0, i >= 2, pat(i - 2), "b_rd");
        for (int i = 8; i < 11; i++)
            add(1, 0, 1, 0, 0, 0, 4'h0, 0, i < 10, 0, i < 10, pat(i - 2), "b_rd_tail");
        add(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, "b_idle");

        foreach (tbl[k])
            step(tbl[k].d, tbl[k].r, tbl[k].c, tbl[k].s, tbl[k].w, tbl[k].adr, tbl[k].sel,
                 tbl[k].wdat, tbl[k].e_ack, tbl[k].e_err, tbl[k].e_dchk, tbl[k].e_dat,
                 $sformatf("%s[%0d]", tbl[k].tag, k), rd);

        // B: cyc dropped for one cycle with reads in flight
        step(1, 0, 1, 1, 0, 'h00, 4'hF, 0, 0, 0, 0, 0, "flush_r0", rd);
        step(1, 0, 1, 1, 0, 'h04, 4'hF, 0, 0, 0, 0, 0, "flush_r1", rd);
        step(1, 0, 1, 1, 0, 'h08, 4'hF, 0, 1, 0, 1, pat(0), "flush_r2", rd);
        step(1, 0, 0, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "flush_drop", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "flush_after1", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "flush_after2", rd);
        step(1, 0, 1, 1, 0, 'h0C, 4'hF, 0, 0, 0, 0, 0, "flush_new_rd", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "flush_new_wait", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 1, 0, 1, pat(3), "flush_new_ack", rd);
        step(1, 0, 0, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "flush_idle", rd);

        // B: one-cycle reset with two reads in flight and a request during reset
        step(1, 0, 1, 1, 0, 'h14, 4'hF, 0, 0, 0, 0, 0, "rstmid_r0", rd);
        step(1, 0, 1, 1, 0, 'h18, 4'hF, 0, 0, 0, 0, 0, "rstmid_r1", rd);
        step(1, 1, 1, 1, 0, 'h1C, 4'hF, 0, 0, 0, 0, 0, "rstmid_rst", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "rstmid_post1", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "rstmid_post2", rd);
        step(1, 0, 1, 1, 0, 'h14, 4'hF, 0, 0, 0, 0, 0, "rstmid_new_rd", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "rstmid_wait", rd);
        step(1, 0, 1, 0, 0, 0,    4'h0, 0, 1, 0, 1, pat(5), "rstmid_ack", rd);
        step(1, 0, 0, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "rstmid_idle", rd);

        // A: write accepted just before cyc drops still lands in RAM
        step(0, 0, 1, 1, 1, 'h30, 4'hF, 32'h12345678, 0, 0, 0, 0, "wrdrop_wr", rd);
        step(0, 0, 0, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "wrdrop_drop", rd);
        step(0, 0, 1, 1, 0, 'h30, 4'hF, 0, 0, 0, 0, 0, "wrdrop_rd", rd);
        step(0, 0, 1, 0, 0, 0,    4'h0, 0, 1, 0, 1, 32'h12345678, "wrdrop_data", rd);
        step(0, 0, 0, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "wrdrop_idle", rd);

        // C: rejected write leaves the word as it was
        step(2, 0, 1, 1, 0, 'h00, 4'hF, 0, 0, 0, 0, 0, "ro_rd_before", rd);
        step(2, 0, 1, 0, 0, 0,    4'h0, 0, 1, 0, 0, 0, "ro_rd_before_ack", rd);
        v0 = rd;
        step(2, 0, 1, 1, 1, 'h00, 4'hF, ~v0, 0, 0, 0, 0, "ro_wr", rd);
        step(2, 0, 1, 0, 0, 0,    4'h0, 0, 0, 1, 0, 0, "ro_wr_err", rd);
        step(2, 0, 1, 1, 0, 'h00, 4'hF, 0, 0, 0, 0, 0, "ro_rd_after", rd);
        step(2, 0, 1, 0, 0, 0,    4'h0, 0, 1, 0, 1, v0, "ro_rd_after_data", rd);
        step(2, 0, 0, 0, 0, 0,    4'h0, 0, 0, 0, 0, 0, "ro_idle", rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
